// File: rtl/a0_uart_logger_pkg.sv
// Shared types and constants for the a0 UART logger.
package a0_uart_logger_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uartStateT;

  localparam int BITS_PER_BYTE  = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / BITS_PER_BYTE;

  function automatic int bytesPerWord(input int width);
    return width / BITS_PER_BYTE;
  endfunction

endpackage

// File: rtl/a0_uart_logger_sync_fifo.sv
// First-word-fall-through FIFO; pointers carry a wrap bit for full/empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wPtr, rPtr;
  logic             doPush, doPop;

  // fullness is judged before any same-cycle pop, so a push while full is dropped
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wPtr <= '0;
      rPtr <= '0;
    end else begin
      if (doPush) wPtr <= wPtr + PTR_ONE;
      if (doPop)  rPtr <= rPtr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wPtr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rPtr[AW-1:0]];
  assign empty = (wPtr == rPtr);
  assign full  = (wPtr[AW] != rPtr[AW]) && (wPtr[AW-1:0] == rPtr[AW-1:0]);
  assign level = wPtr - rPtr;
endmodule

// File: rtl/a0_uart_logger.sv
// Logs every change of a0 into a FIFO and sends each word as four 8N1 bytes, LSB first.
import a0_uart_logger_pkg::*;

module a0_uart_logger #(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         a0,
  input  logic                          en,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int BPW = bytesPerWord(DATA_WIDTH);
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(BPW - 1);

  logic [DATA_WIDTH-1:0] a0Q, rdata, shReg, shNxt;
  logic                  push, pop, full, empty, baudDone, txNxt, busyNxt;
  uartStateT             state, stateNxt;
  logic [CW-1:0]         baudCnt, baudNxt;
  logic [2:0]            bitIdx, bitNxt;
  logic [BW-1:0]         byteIdx, byteNxt;

  assign push = en && (a0 != a0Q);

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) uFifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .wdata(a0),
    .rdata(rdata), .full(full), .empty(empty), .level(level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a0Q      <= '0;
      overflow <= 1'b0;
    end else begin
      a0Q <= a0;
      if (push && full) overflow <= 1'b1;
    end
  end

  // state register; tx/busy are registered from next-state values so they stay glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      baudCnt <= '0;
      bitIdx  <= '0;
      byteIdx <= '0;
      shReg   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= stateNxt;
      baudCnt <= baudNxt;
      bitIdx  <= bitNxt;
      byteIdx <= byteNxt;
      shReg   <= shNxt;
      tx      <= txNxt;
      busy    <= busyNxt;
    end
  end

  assign baudDone = (baudCnt == BAUD_LAST);

  always_comb begin
    stateNxt = state;
    baudNxt  = baudCnt;
    bitNxt   = bitIdx;
    byteNxt  = byteIdx;
    shNxt    = shReg;
    pop      = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop      = 1'b1;
        shNxt    = rdata;
        byteNxt  = '0;
        baudNxt  = '0;
        stateNxt = START;
      end
      START: if (baudDone) begin
        baudNxt  = '0;
        bitNxt   = '0;
        stateNxt = DATA;
      end else baudNxt = baudCnt + CW'(1);
      DATA: if (baudDone) begin
        baudNxt = '0;
        if (bitIdx == 3'd7) stateNxt = STOP;
        else                bitNxt   = bitIdx + 3'd1;
      end else baudNxt = baudCnt + CW'(1);
      STOP: if (baudDone) begin
        baudNxt = '0;
        if (byteIdx == BYTE_LAST) stateNxt = IDLE;
        else begin
          byteNxt  = byteIdx + BW'(1);
          shNxt    = shReg >> BITS_PER_BYTE;
          stateNxt = START;
        end
      end else baudNxt = baudCnt + CW'(1);
      default: stateNxt = IDLE;
    endcase
  end

  always_comb begin
    txNxt   = 1'b1;
    busyNxt = (stateNxt != IDLE);
    case (stateNxt)
      START:   txNxt = 1'b0;
      DATA:    txNxt = shNxt[bitNxt];
      default: txNxt = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_a0_uart_logger.sv
// Scoreboard bench: stimulus queues expected words, a UART monitor decodes tx and compares.
module tb_a0_uart_logger;
  logic        clk, rst, en;
  logic [31:0] a0;
  logic        tx, busy, overflow;
  logic [3:0]  level;

  int checks = 0;
  int failures = 0;
  int epoch = 0;
  logic [31:0] expQ [$];

  a0_uart_logger #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .a0(a0), .en(en),
    .tx(tx), .busy(busy), .overflow(overflow), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge rst) epoch++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic waitDrain(input string name, input int budget);
    int c = 0;
    while ((expQ.size() != 0 || busy) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, 64'(expQ.size() == 0 && !busy), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  // UART monitor: start detected on first low cycle, bits sampled mid-period
  initial begin
    logic [7:0]  b;
    logic [31:0] w;
    int nb;
    int ep;
    nb = 0;
    ep = 0;
    b  = '0;
    w  = '0;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        if (nb == 0) ep = epoch;
        repeat (2) @(negedge clk);
        check("mon_start_bit", 64'(tx), 64'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = tx;
        end
        repeat (4) @(negedge clk);
        if (epoch != ep) nb = 0;
        else begin
          check("mon_stop_bit", 64'(tx), 64'd1);
          w[nb*8 +: 8] = b;
          nb++;
          if (nb == 4) begin
            nb = 0;
            if (expQ.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL mon_unexpected_word actual=%0h required=none", w);
            end else check("mon_word", 64'(w), 64'(expQ.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int highs;
    rst = 1'b1;
    a0  = '0;
    en  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", 64'({tx, busy, overflow, level}), 64'({1'b1, 1'b0, 1'b0, 4'd0}));
    rst = 1'b0;

    // 1. idle line
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check("idle", 64'({tx, busy, overflow, level}), 64'({1'b1, 1'b0, 1'b0, 4'd0}));
    end

    // 2. single word, latency and busy fall
    a0 = 32'h12345678;
    expQ.push_back(32'h12345678);
    @(negedge clk);
    check("t2_level_n1", 64'(level), 64'd1);
    check("t2_tx_n1", 64'(tx), 64'd1);
    @(negedge clk);
    check("t2_tx_n2", 64'(tx), 64'd0);
    check("t2_busy_n2", 64'(busy), 64'd1);
    repeat (159) @(negedge clk);
    check("t2_busy_n161", 64'(busy), 64'd1);
    @(negedge clk);
    check("t2_busy_n162", 64'(busy), 64'd0);
    waitDrain("t2_drain", 400);

    // 3. back-to-back words and inter-word gap
    a0 = 32'h0000000A;
    expQ.push_back(32'h0000000A);
    @(negedge clk);
    a0 = 32'h0000000B;
    expQ.push_back(32'h0000000B);
    repeat (156) @(negedge clk);
    check("t3_last_data_bit", 64'(tx), 64'd0);
    highs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tx) highs++;
    end
    check("t3_idle_busy", 64'(busy), 64'd0);
    check("t3_gap_highs", 64'(highs), 64'd5);
    @(negedge clk);
    check("t3_word2_start", 64'(tx), 64'd0);
    waitDrain("t3_drain", 400);

    // 4. overflow
    for (int v = 1; v <= 12; v++) begin
      a0 = 32'(v);
      if (v <= 9) expQ.push_back(32'(v));
      @(negedge clk);
      if (v == 9) begin
        check("t4_level_full", 64'(level), 64'd8);
        check("t4_ovf_before", 64'(overflow), 64'd0);
      end
      if (v == 10) check("t4_ovf_set", 64'(overflow), 64'd1);
    end
    check("t4_level_after", 64'(level), 64'd8);
    waitDrain("t4_drain", 2000);
    check("t4_ovf_sticky", 64'(overflow), 64'd1);

    // 5. enable gating
    en = 1'b0;
    a0 = 32'd5;
    @(negedge clk);
    a0 = 32'd6;
    @(negedge clk);
    a0 = 32'd7;
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_gated", 64'({tx, busy, level}), 64'({1'b1, 1'b0, 4'd0}));
    end
    a0 = 32'd8;
    expQ.push_back(32'd8);
    waitDrain("t5_drain", 400);

    // 6. asynchronous reset mid-frame, then resend
    a0 = 32'hDEADBEEF;
    repeat (15) @(negedge clk);
    check("t6_busy_pre", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_rst", 64'({tx, busy, overflow, level}), 64'({1'b1, 1'b0, 1'b0, 4'd0}));
    repeat (60) @(negedge clk);
    expQ.push_back(32'hDEADBEEF);
    rst = 1'b0;
    @(negedge clk);
    check("t6_repush_level", 64'(level), 64'd1);
    waitDrain("t6_drain", 400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
